// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the program-counter sequencer: operand-A mux select
// values and the 3-bit sequencer state encoding.
package pc_sequencer_pkg;

  localparam logic PC_JUMP = 1'b1;
  localparam logic PC_INC  = 1'b0;

  typedef enum logic [2:0] {
    PCS_IDLE  = 3'd0,
    PCS_FETCH = 3'd1,
    PCS_EXEC  = 3'd2,
    PCS_HALT  = 3'd3,
    PCS_ERR   = 3'd4
  } pcs_state_e;

  // States from which a start pulse is honoured.
  function automatic logic pcs_restartable(pcs_state_e s);
    return (s == PCS_IDLE) || (s == PCS_HALT) || (s == PCS_ERR);
  endfunction

endpackage

// File: rtl/pc_sequencer_fetch_timer.sv
// Counts FETCH cycles without an ack; expired_o flags the cycle in which the
// count would reach ACK_TIMEOUT, so the ACK_TIMEOUT-th unanswered cycle errors.
module pc_sequencer_fetch_timer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && !clr_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, runs fetch/execute against
// instruction memory and steers the operand-A mux on branches.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int PC_STEP     = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [PC_WIDTH-1:0]    i_start_pc,
  output logic                   o_imem_req,
  output logic [PC_WIDTH-1:0]    o_imem_addr,
  input  logic                   i_imem_ack,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic                   o_instr_valid,
  input  logic                   i_is_branch,
  input  logic                   i_branch_taken,
  input  logic                   i_halt,
  input  logic                   i_exec_done,
  input  logic [PC_WIDTH-1:0]    i_alu_result,
  output logic                   o_branch_sel,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic                   o_busy,
  output logic                   o_halted,
  output logic                   o_err
);

  localparam logic [PC_WIDTH-1:0] PC_INCR    = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {PC_WIDTH{1'b1}} << $clog2(PC_STEP);

  pcs_state_e             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   req_q, busy_q, halted_q, err_q;
  logic                   tmr_clr, tmr_en, tmr_expired;

  pc_sequencer_fetch_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_fetch_timer (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    tmr_clr = 1'b1;
    tmr_en  = 1'b0;
    case (state_q)
      PCS_IDLE, PCS_HALT, PCS_ERR: begin
        if (i_start) begin
          pc_d    = i_start_pc;
          state_d = PCS_FETCH;
        end
      end
      PCS_FETCH: begin
        // An ack in the final allowed cycle still wins over the timeout.
        tmr_clr = i_imem_ack;
        tmr_en  = !i_imem_ack;
        if (i_imem_ack) begin
          instr_d = i_instr;
          valid_d = 1'b1;
          state_d = PCS_EXEC;
        end else if (tmr_expired) begin
          state_d = PCS_ERR;
        end
      end
      PCS_EXEC: begin
        if (i_exec_done) begin
          if (i_halt) begin
            state_d = PCS_HALT;
          end else if (i_is_branch && i_branch_taken) begin
            pc_d    = i_alu_result & ALIGN_MASK;
            state_d = PCS_FETCH;
          end else begin
            pc_d    = pc_q + PC_INCR;
            state_d = PCS_FETCH;
          end
        end
      end
      default: state_d = PCS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= PCS_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      req_q    <= (state_d == PCS_FETCH);
      busy_q   <= (state_d == PCS_FETCH) || (state_d == PCS_EXEC);
      halted_q <= (state_d == PCS_HALT);
      err_q    <= (state_d == PCS_ERR);
    end
  end

  // Operand A carries the PC for the whole branch execute, so this stays combinational.
  assign o_branch_sel  = ((state_q == PCS_EXEC) && i_is_branch) ? PC_JUMP : PC_INC;

  assign o_pc          = pc_q;
  assign o_imem_addr   = pc_q;
  assign o_imem_req    = req_q;
  assign o_instr       = instr_q;
  assign o_instr_valid = valid_q;
  assign o_busy        = busy_q;
  assign o_halted      = halted_q;
  assign o_err         = err_q;

  // Restart is only legal from an idle-like state; keeps the helper tied to the FSM.
  logic unused_restart;
  assign unused_restart = pcs_restartable(state_q);

endmodule
